bru_bco_queue: RTL and testbench

Buffers branch-outcome (BCO) records produced by the branch execution unit and drains them to the branch predictor update port under a valid/ready handshake. It sits directly downstream of the BRU output register stage. It computes the new 2-bit saturating pattern per record and coalesces back-to-back updates to the same PC. The BRU cannot be stalled, so the block raises a near-full flag toward branch issue and counts any records it drops.

---
 rtl/bru_bco_queue_pkg.sv | 17 +
 rtl/bru_bco_queue_fifo.sv | 56 +++++
 rtl/bru_bco_queue.sv | 75 +++++++
 tb/tb_bru_bco_queue.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/bru_bco_queue_pkg.sv
// Shared types and helpers for the branch-outcome queue feeding the predictor.
package bru_bco_queue_pkg;
  localparam int BCO_DEPTH = 4;

  typedef struct packed {
    logic [31:0] pc;
    logic [1:0]  pattern;
    logic        taken;
    logic [31:0] target;
  } bco_entry_t;

  // 2-bit saturating counter step toward the resolved direction
  function automatic logic [1:0] sat2(input logic [1:0] p, input logic t);
    if (t) return (p == 2'd3) ? 2'd3 : p + 2'd1;
    else   return (p == 2'd0) ? 2'd0 : p - 2'd1;
  endfunction
endpackage

// File: rtl/bru_bco_queue_fifo.sv
// Circular entry store with head/tail read ports and an in-place tail rewrite.
module bru_bco_queue_fifo
  import bru_bco_queue_pkg::*;
#(
  parameter int DEPTH = BCO_DEPTH,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          push,
  input  bco_entry_t    push_data,
  input  logic          pop,
  input  logic          tail_wr,
  input  bco_entry_t    tail_data,
  output bco_entry_t    head,
  output logic [31:0]   tail_pc,
  output logic [1:0]    tail_pattern,
  output logic [CW-1:0] count,
  output logic [CW-1:0] count_nxt
);
  bco_entry_t    mem [DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr, tail_ptr;

  assign tail_ptr     = wr_ptr - AW'(1);
  assign head         = mem[rd_ptr];
  assign tail_pc      = mem[tail_ptr].pc;
  assign tail_pattern = mem[tail_ptr].pattern;

  always_comb begin
    count_nxt = count;
    case ({push, pop})
      2'b10:   count_nxt = count + CW'(1);
      2'b01:   count_nxt = count - CW'(1);
      default: count_nxt = count;
    endcase
  end

  // Power-of-two depth lets the pointers wrap by plain overflow
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (tail_wr) mem[tail_ptr] <= tail_data;
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      count <= count_nxt;
    end
  end
endmodule

// File: rtl/bru_bco_queue.sv
// BRU branch-outcome queue: coalesces same-PC updates, drops on overflow, drains to the BPU.
module bru_bco_queue
  import bru_bco_queue_pkg::*;
#(
  parameter int DEPTH = BCO_DEPTH
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        i_bco_valid,
  input  logic [31:0] i_bco_pc,
  input  logic [1:0]  i_bco_oldpattern,
  input  logic        i_bco_taken,
  input  logic [31:0] i_bco_target,
  output logic        o_bpu_valid,
  input  logic        i_bpu_ready,
  output logic [31:0] o_bpu_pc,
  output logic [1:0]  o_bpu_pattern,
  output logic        o_bpu_taken,
  output logic [31:0] o_bpu_target,
  output logic        o_nearfull,
  output logic [7:0]  o_drop_cnt
);
  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);
  localparam logic [CW-1:0] NEAR = CW'(DEPTH - 1);

  bco_entry_t    head, push_data, tail_data;
  logic [31:0]   tail_pc;
  logic [1:0]    tail_pattern;
  logic [CW-1:0] count, count_nxt;
  logic          pop, coalesce, push, drop;

  assign pop = (count != '0) && i_bpu_ready;
  // A lone entry leaving this cycle can't absorb the update; it becomes an append instead
  assign coalesce = i_bco_valid && (count != '0) && (tail_pc == i_bco_pc) &&
                    !((count == CW'(1)) && pop);
  assign push = i_bco_valid && !coalesce && ((count != FULL) || pop);
  assign drop = i_bco_valid && !coalesce && !push;

  assign push_data = '{pc: i_bco_pc, pattern: sat2(i_bco_oldpattern, i_bco_taken),
                       taken: i_bco_taken, target: i_bco_target};
  assign tail_data = '{pc: i_bco_pc, pattern: sat2(tail_pattern, i_bco_taken),
                       taken: i_bco_taken, target: i_bco_target};

  bru_bco_queue_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk          (clk),
    .resetn       (resetn),
    .push         (push),
    .push_data    (push_data),
    .pop          (pop),
    .tail_wr      (coalesce),
    .tail_data    (tail_data),
    .head         (head),
    .tail_pc      (tail_pc),
    .tail_pattern (tail_pattern),
    .count        (count),
    .count_nxt    (count_nxt)
  );

  assign o_bpu_valid   = (count != '0);
  assign o_bpu_pc      = head.pc;
  assign o_bpu_pattern = head.pattern;
  assign o_bpu_taken   = head.taken;
  assign o_bpu_target  = head.target;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      o_nearfull <= 1'b0;
      o_drop_cnt <= '0;
    end else begin
      o_nearfull <= (count_nxt >= NEAR);
      if (drop && (o_drop_cnt != 8'hff)) o_drop_cnt <= o_drop_cnt + 8'd1;
    end
  end
endmodule

// File: tb/tb_bru_bco_queue.sv
// Bench for bru_bco_queue: pattern table, directed corner sequences, random traffic vs a queue model.
module tb_bru_bco_queue;
  localparam int DEPTH = 4;

  logic        clk, resetn;
  logic        i_bco_valid, i_bco_taken, i_bpu_ready;
  logic [31:0] i_bco_pc, i_bco_target;
  logic [1:0]  i_bco_oldpattern;
  logic        o_bpu_valid, o_bpu_taken, o_nearfull;
  logic [31:0] o_bpu_pc, o_bpu_target;
  logic [1:0]  o_bpu_pattern;
  logic [7:0]  o_drop_cnt;

  bru_bco_queue #(.DEPTH(DEPTH)) dut (
    .clk(clk), .resetn(resetn),
    .i_bco_valid(i_bco_valid), .i_bco_pc(i_bco_pc), .i_bco_oldpattern(i_bco_oldpattern),
    .i_bco_taken(i_bco_taken), .i_bco_target(i_bco_target),
    .o_bpu_valid(o_bpu_valid), .i_bpu_ready(i_bpu_ready),
    .o_bpu_pc(o_bpu_pc), .o_bpu_pattern(o_bpu_pattern), .o_bpu_taken(o_bpu_taken),
    .o_bpu_target(o_bpu_target), .o_nearfull(o_nearfull), .o_drop_cnt(o_drop_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0, errors = 0;

  typedef struct {
    logic [31:0] pc;
    logic [1:0]  pat;
    logic        tk;
    logic [31:0] tgt;
  } ment_t;
  ment_t q[$];
  int    drops = 0;

  typedef struct {
    logic [31:0] pc;
    logic [1:0]  old;
    logic        taken;
    logic [31:0] tgt;
    logic [1:0]  exp_pat;
  } vec_t;
  vec_t vt[6];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [1:0] nxt_pat(input int p, input bit t);
    int r;
    r = t ? p + 1 : p - 1;
    if (r > 3) r = 3;
    if (r < 0) r = 0;
    return r[1:0];
  endfunction

  task automatic check_model();
    chk("valid", o_bpu_valid, q.size() != 0);
    if (q.size() != 0) begin
      chk("head_pc", o_bpu_pc, q[0].pc);
      chk("head_pattern", o_bpu_pattern, q[0].pat);
      chk("head_taken", o_bpu_taken, q[0].tk);
      chk("head_target", o_bpu_target, q[0].tgt);
    end
    chk("nearfull", o_nearfull, q.size() >= DEPTH - 1);
    chk("drop_cnt", o_drop_cnt, drops);
  endtask

  // One clock: check current outputs, drive inputs, advance the model, cross the edge.
  task automatic step(input logic v, input logic [31:0] pc, input logic [1:0] old,
                      input logic t, input logic [31:0] tgt, input logic rdy);
    int    sz;
    bit    pop, app;
    ment_t e;
    check_model();
    i_bco_valid = v; i_bco_pc = pc; i_bco_oldpattern = old;
    i_bco_taken = t; i_bco_target = tgt; i_bpu_ready = rdy;
    sz  = q.size();
    pop = (sz > 0) && rdy;
    app = 0;
    if (v) begin
      if (sz >= 1 && q[sz-1].pc == pc && !(sz == 1 && pop)) begin
        e = q[sz-1];
        e.pat = nxt_pat(int'(e.pat), t);
        e.tk  = t;
        e.tgt = tgt;
        q[sz-1] = e;
      end else if (sz < DEPTH || pop) app = 1;
      else if (drops < 255) drops++;
    end
    if (pop) void'(q.pop_front());
    if (app) begin
      e.pc = pc; e.pat = nxt_pat(int'(old), t); e.tk = t; e.tgt = tgt;
      q.push_back(e);
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle(input logic rdy);
    step(1'b0, 32'h0, 2'd0, 1'b0, 32'h0, rdy);
  endtask

  initial begin
    vt[0] = '{32'h0000_1000, 2'd1, 1'b1, 32'hdead_0000, 2'd2};
    vt[1] = '{32'h0000_1100, 2'd3, 1'b1, 32'hdead_0004, 2'd3};
    vt[2] = '{32'h0000_1200, 2'd0, 1'b0, 32'hdead_0008, 2'd0};
    vt[3] = '{32'h0000_1300, 2'd2, 1'b0, 32'hdead_000c, 2'd1};
    vt[4] = '{32'h0000_1400, 2'd1, 1'b0, 32'hdead_0010, 2'd0};
    vt[5] = '{32'h0000_1500, 2'd2, 1'b1, 32'hdead_0014, 2'd3};

    resetn = 1'b0;
    i_bco_valid = 0; i_bco_pc = 0; i_bco_oldpattern = 0;
    i_bco_taken = 0; i_bco_target = 0; i_bpu_ready = 0;
    repeat (2) @(negedge clk);
    chk("rst_valid", o_bpu_valid, 0);
    chk("rst_pc", o_bpu_pc, 0);
    chk("rst_target", o_bpu_target, 0);
    chk("rst_pattern", o_bpu_pattern, 0);
    chk("rst_nearfull", o_nearfull, 0);
    chk("rst_drop", o_drop_cnt, 0);
    resetn = 1'b1;

    // Single records into an empty queue, popped the following cycle
    for (int i = 0; i < 6; i++) begin
      step(1'b1, vt[i].pc, vt[i].old, vt[i].taken, vt[i].tgt, 1'b1);
      chk("tbl_valid", o_bpu_valid, 1);
      chk("tbl_pc", o_bpu_pc, vt[i].pc);
      chk("tbl_pattern", o_bpu_pattern, vt[i].exp_pat);
      chk("tbl_taken", o_bpu_taken, vt[i].taken);
      chk("tbl_target", o_bpu_target, vt[i].tgt);
      idle(1'b1);
      chk("tbl_empty", o_bpu_valid, 0);
    end

    // Coalesce into a single stalled head
    step(1'b1, 32'h2000, 2'd1, 1'b1, 32'haaaa_0001, 1'b0);
    step(1'b1, 32'h2000, 2'd0, 1'b1, 32'haaaa_0002, 1'b0);
    chk("coal_pattern", o_bpu_pattern, 3);
    chk("coal_target", o_bpu_target, 32'haaaa_0002);
    chk("coal_nearfull", o_nearfull, 0);
    idle(1'b1);
    chk("coal_count1", o_bpu_valid, 0);

    // Fill past capacity, then drain in order
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 32'h3000 + 32'(i * 4), 2'd1, 1'b0, 32'hbbbb_0000 + 32'(i), 1'b0);
      if (i == 1) chk("fill_nf2", o_nearfull, 0);
      if (i == 2) chk("fill_nf3", o_nearfull, 1);
    end
    chk("fill_drop", o_drop_cnt, 1);
    for (int i = 0; i < 4; i++) begin
      chk("drain_pc", o_bpu_pc, 32'h3000 + 32'(i * 4));
      idle(1'b1);
    end
    chk("drain_empty", o_bpu_valid, 0);

    // Full with push and pop in the same cycle
    for (int i = 0; i < 4; i++)
      step(1'b1, 32'h4000 + 32'(i * 4), 2'd2, 1'b1, 32'hcccc_0000 + 32'(i), 1'b0);
    step(1'b1, 32'h4010, 2'd2, 1'b0, 32'hcccc_0010, 1'b1);
    chk("fullpp_drop", o_drop_cnt, 1);
    chk("fullpp_nf", o_nearfull, 1);
    for (int i = 0; i < 4; i++) begin
      chk("fullpp_pc", o_bpu_pc, 32'h4004 + 32'(i * 4));
      idle(1'b1);
    end
    chk("fullpp_empty", o_bpu_valid, 0);

    // Drop counter saturation
    for (int i = 0; i < 304; i++)
      step(1'b1, 32'h6000 + 32'(i * 4), 2'd0, 1'b1, 32'(i), 1'b0);
    chk("drop_sat", o_drop_cnt, 255);
    repeat (4) idle(1'b1);

    // Asynchronous reset with entries queued
    for (int i = 0; i < 3; i++)
      step(1'b1, 32'h7000 + 32'(i * 4), 2'd1, 1'b1, 32'hdddd_0000 + 32'(i), 1'b0);
    idle(1'b0);
    chk("pre_rst_valid", o_bpu_valid, 1);
    #2 resetn = 1'b0;
    #1;
    chk("mid_rst_valid", o_bpu_valid, 0);
    chk("mid_rst_drop", o_drop_cnt, 0);
    chk("mid_rst_nf", o_nearfull, 0);
    chk("mid_rst_pc", o_bpu_pc, 0);
    q.delete();
    drops = 0;
    @(negedge clk);
    resetn = 1'b1;
    step(1'b1, 32'h8000, 2'd2, 1'b0, 32'heeee_0000, 1'b0);
    chk("post_rst_pc", o_bpu_pc, 32'h8000);
    chk("post_rst_pattern", o_bpu_pattern, 1);

    // Random traffic over a small PC set so coalesces and drops occur
    for (int i = 0; i < 1500; i++)
      step($urandom_range(0, 3) != 0, 32'h5000 + 32'($urandom_range(0, 3) * 4),
           2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), $urandom,
           $urandom_range(0, 2) == 0);
    repeat (6) idle(1'b1);
    check_model();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
